// File: rtl/dottori_rom_loader.sv
// Byte-stream feeder for the Dottori-Kun program ROM download port; holds the core
// in reset during a load. Define DOTTORI_LOADER_CHECKSUM_EN to add the LOAD_OK sum check.
module dottori_rom_loader #(
  parameter int ROM_BYTES   = 8192,
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_GAP      = 1,
  parameter int HOLD_CYCLES = 16
`ifdef DOTTORI_LOADER_CHECKSUM_EN
  , parameter logic [7:0] EXPECTED_SUM = 8'h00
`endif
) (
  input  logic        CLK_4M,
  input  logic        nRESET,
  input  logic        DL_ACTIVE,
  input  logic        DL_VALID,
  input  logic [7:0]  DL_DATA,
  output logic        DL_READY,
  output logic [13:0] dn_addr,
  output logic        dn_wr,
  output logic [7:0]  dn_data,
  output logic        nCORE_RESET,
  output logic [14:0] BYTE_COUNT,
  output logic        OVERFLOW
`ifdef DOTTORI_LOADER_CHECKSUM_EN
  , output logic      LOAD_OK
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 2);
  localparam int GW = $clog2(WR_GAP + 2);
  localparam logic [14:0]   ROM_LIM   = 15'(ROM_BYTES);
  localparam logic [14:0]   CNT_MAX   = '1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_INIT  = GW'(WR_GAP);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;
  state_t state, state_next;

  logic          dl_active_q;
  logic          rise;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, accept, push, pop;
  logic [7:0]    fifo_out;
  logic [GW-1:0] gap;
  logic [HW-1:0] hold;
  logic [13:0]   wr_addr;

  assign rise     = DL_ACTIVE & ~dl_active_q;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_out = mem[rd_ptr[AW-1:0]];
  // Ready reflects occupancy before any same-cycle pop, so a full FIFO never accepts.
  assign DL_READY = (state == LOAD) & ~full;
  assign accept   = DL_VALID & DL_READY;
  assign push     = accept & (BYTE_COUNT < ROM_LIM);
  assign pop      = ((state == LOAD) || (state == DRAIN)) & ~empty & (gap == '0) & ~rise;

  always_ff @(posedge CLK_4M or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (rise) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = HOLD;
        LOAD:    if (!DL_ACTIVE) state_next = DRAIN;
        DRAIN:   if (empty && (gap == '0)) state_next = HOLD;
        HOLD:    if (hold == '0) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_4M or negedge nRESET) begin
    if (!nRESET) begin
      dl_active_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      gap         <= '0;
      hold        <= HOLD_INIT;
      wr_addr     <= '0;
      dn_addr     <= '0;
      dn_wr       <= 1'b0;
      dn_data     <= '0;
      nCORE_RESET <= 1'b0;
      BYTE_COUNT  <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      dl_active_q <= DL_ACTIVE;
      nCORE_RESET <= (state_next == RUN);
      dn_wr       <= pop;
      if (rise) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        gap        <= '0;
        wr_addr    <= '0;
        BYTE_COUNT <= '0;
        OVERFLOW   <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          dn_addr <= wr_addr;
          dn_data <= fifo_out;
          wr_addr <= wr_addr + 1'b1;
          gap     <= GAP_INIT;
        end else if (gap != '0) begin
          gap <= gap - 1'b1;
        end
        if (accept) begin
          if (BYTE_COUNT != CNT_MAX) BYTE_COUNT <= BYTE_COUNT + 1'b1;
          if (!push) OVERFLOW <= 1'b1;
        end
      end
      if ((state == IDLE) || ((state == DRAIN) && (state_next == HOLD))) hold <= HOLD_INIT;
      else if ((state == HOLD) && (hold != '0)) hold <= hold - 1'b1;
    end
  end

  always_ff @(posedge CLK_4M) begin
    if (push) mem[wr_ptr[AW-1:0]] <= DL_DATA;
  end

`ifdef DOTTORI_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  // The verdict is latched once, on the transition into RUN.
  always_ff @(posedge CLK_4M or negedge nRESET) begin
    if (!nRESET) begin
      sum     <= '0;
      LOAD_OK <= 1'b0;
    end else if (rise) begin
      sum     <= '0;
      LOAD_OK <= 1'b0;
    end else begin
      if (pop) sum <= sum + fifo_out;
      if ((state_next == RUN) && (state != RUN)) LOAD_OK <= (sum == EXPECTED_SUM) && !OVERFLOW;
    end
  end
`endif

endmodule
